// File: rtl/multi_digit_display.sv
`default_nettype none
// ============================================================================
// Module  : multi_digit_display
// Brief   : Decimal number object: double-dabble BCD, glyph ROM, LZ blank, blink.
// Revision: 1.0
// ============================================================================
module multi_digit_display #(
  parameter int         NUM_DIGITS   = 4,
  parameter int         VALUE_W      = 14,
  parameter int         SCALE_SHIFT  = 0,
  parameter logic [7:0] DIGIT_COLOR  = 8'h00,
  parameter bit         BLANK_LZ     = 1'b1,
  parameter int         BLINK_FRAMES = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               value_valid,
  input  logic [VALUE_W-1:0] value_in,
  output logic               value_ready,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic [10:0]        topLeftX,
  input  logic [10:0]        topLeftY,
  input  logic               blink_en,
  output logic               drawingRequest,
  output logic [7:0]         RGBout
);

  localparam int                c_bcd_w   = 4 * NUM_DIGITS;
  localparam int                c_cnt_w   = $clog2(VALUE_W + 1);
  localparam int                c_blk_w   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0]       c_max_val = 32'(10 ** NUM_DIGITS - 1);
  localparam logic signed [11:0] c_obj_w  = 12'(NUM_DIGITS * (16 << SCALE_SHIFT));
  localparam logic signed [11:0] c_obj_h  = 12'(32 << SCALE_SHIFT);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_WAIT} state_t;

  state_t               r_state, w_next;
  logic [VALUE_W-1:0]   r_bin;
  logic [c_bcd_w-1:0]   r_bcd, w_adj, r_shown;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_sat;
  logic [c_blk_w-1:0]   r_blk_cnt;
  logic                 r_phase_on;
  logic                 r_draw;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (value_valid) w_next = ST_CONV;
      ST_CONV: if (r_cnt == c_cnt_w'(VALUE_W - 1)) w_next = ST_WAIT;
      ST_WAIT: if (startOfFrame) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign value_ready = (r_state == ST_IDLE);

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_shown <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (value_valid) begin
          r_bin <= value_in;
          r_bcd <= '0;
          r_cnt <= '0;
          r_sat <= (32'(value_in) > c_max_val);
        end
        ST_CONV: begin
          r_bcd <= c_bcd_w'({w_adj, r_bin[VALUE_W-1]});
          r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        ST_WAIT: if (startOfFrame) r_shown <= r_sat ? {NUM_DIGITS{4'd9}} : r_bcd;
        default: ;
      endcase
    end
  end

  // Blink phase: toggles every BLINK_FRAMES frame starts while enabled
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_blk_cnt  <= '0;
      r_phase_on <= 1'b1;
    end else if (!blink_en) begin
      r_blk_cnt  <= '0;
      r_phase_on <= 1'b1;
    end else if (startOfFrame) begin
      if (r_blk_cnt == c_blk_w'(BLINK_FRAMES - 1)) begin
        r_blk_cnt  <= '0;
        r_phase_on <= ~r_phase_on;
      end else begin
        r_blk_cnt  <= r_blk_cnt + c_blk_w'(1);
      end
    end
  end

  // Seven-segment style 16x32 glyphs, seg = {a,b,c,d,e,f,g}
  function automatic logic [15:0] glyph_row(input logic [3:0] d, input logic [4:0] r);
    logic [6:0]  seg;
    logic [15:0] row;
    case (d)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    row = 16'h0000;
    if (seg[6] && r <= 5'd3)                row = row | 16'h1FF8;
    if (seg[0] && r >= 5'd14 && r <= 5'd17) row = row | 16'h1FF8;
    if (seg[3] && r >= 5'd28)               row = row | 16'h1FF8;
    if (seg[5] && r <= 5'd17)               row = row | 16'h001C;
    if (seg[4] && r >= 5'd14)               row = row | 16'h001C;
    if (seg[2] && r >= 5'd14)               row = row | 16'h3800;
    if (seg[1] && r <= 5'd17)               row = row | 16'h3800;
    return row;
  endfunction

  logic signed [11:0] w_off_x, w_off_y;
  logic               w_inside, w_blank, w_lz, w_pix;
  logic [2:0]         w_k;
  logic [3:0]         w_col, w_digit;
  logic [4:0]         w_row;
  logic [15:0]        w_row_bits;

  assign w_off_x  = {1'b0, pixelX} - {1'b0, topLeftX};
  assign w_off_y  = {1'b0, pixelY} - {1'b0, topLeftY};
  assign w_inside = !w_off_x[11] && !w_off_y[11] && (w_off_x < c_obj_w) && (w_off_y < c_obj_h);
  assign w_k      = w_off_x[4+SCALE_SHIFT +: 3];
  assign w_col    = w_off_x[SCALE_SHIFT +: 4];
  assign w_row    = w_off_y[SCALE_SHIFT +: 5];

  // w_lz tracks "all digits from the MS end up to i are zero"
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    w_lz    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_lz = w_lz && (r_shown[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (w_k == 3'(i)) begin
        w_digit = r_shown[4*(NUM_DIGITS-1-i) +: 4];
        w_blank = BLANK_LZ && (i < NUM_DIGITS - 1) && w_lz;
      end
    end
  end

  assign w_row_bits = glyph_row(w_digit, w_row);
  assign w_pix      = w_row_bits[4'd15 - w_col];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_draw <= 1'b0;
    else         r_draw <= w_inside && !w_blank && r_phase_on && w_pix;
  end

  assign drawingRequest = r_draw;
  assign RGBout         = DIGIT_COLOR;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_digit_display
// Brief   : Scoreboard bench for multi_digit_display (scale 1x and 2x instances).
// Revision: 1.0
// ============================================================================
module tb_multi_digit_display;

  localparam int VW  = 14;
  localparam int TLX = 200;
  localparam int TLY = 100;

  logic          clk = 1'b0;
  logic          resetN, startOfFrame, value_valid, blink_en;
  logic [VW-1:0] value_in;
  logic [10:0]   pixelX, pixelY, topLeftX, topLeftY;
  logic          rdy0, rdy1, dr0, dr1;
  logic [7:0]    rgb0, rgb1;

  always #5 clk = ~clk;

  multi_digit_display #(.NUM_DIGITS(4), .VALUE_W(VW), .SCALE_SHIFT(0), .DIGIT_COLOR(8'h00),
                        .BLANK_LZ(1'b1), .BLINK_FRAMES(2)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .value_valid(value_valid),
    .value_in(value_in), .value_ready(rdy0), .pixelX(pixelX), .pixelY(pixelY),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .blink_en(blink_en),
    .drawingRequest(dr0), .RGBout(rgb0));

  multi_digit_display #(.NUM_DIGITS(4), .VALUE_W(VW), .SCALE_SHIFT(1), .DIGIT_COLOR(8'hE0),
                        .BLANK_LZ(1'b1), .BLINK_FRAMES(2)) dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .value_valid(value_valid),
    .value_in(value_in), .value_ready(rdy1), .pixelX(pixelX), .pixelY(pixelY),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .blink_en(blink_en),
    .drawingRequest(dr1), .RGBout(rgb1));

  int n_checks = 0;
  int n_pass   = 0;
  int model_val = 0;
  bit model_on  = 1'b1;

  typedef struct { bit e0; bit e1; } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit glyph_bit(input int d, input int r, input int c);
    bit [6:0] s;
    bit hz, lf, rt;
    case (d)
      0: s = 7'b1111110; 1: s = 7'b0110000; 2: s = 7'b1101101; 3: s = 7'b1111001;
      4: s = 7'b0110011; 5: s = 7'b1011011; 6: s = 7'b1011111; 7: s = 7'b1110000;
      8: s = 7'b1111111; default: s = 7'b1111011;
    endcase
    hz = (c >= 3 && c <= 12);
    lf = (c >= 2 && c <= 4);
    rt = (c >= 11 && c <= 13);
    return (s[6] && r <= 3 && hz) || (s[0] && r >= 14 && r <= 17 && hz) ||
           (s[3] && r >= 28 && hz) || (s[5] && r <= 17 && rt) ||
           (s[4] && r >= 14 && rt) || (s[2] && r >= 14 && lf) || (s[1] && r <= 17 && lf);
  endfunction

  function automatic bit model_pix(input int s, input int ox, input int oy, input int val, input bit on);
    int k, p, d;
    if (ox < 0 || oy < 0 || ox >= 4 * (16 << s) || oy >= (32 << s) || !on) return 1'b0;
    k = ox >> (4 + s);
    p = 1;
    for (int i = 0; i < 3 - k; i++) p = p * 10;
    if (k < 3 && val < p) return 1'b0;
    d = (val / p) % 10;
    return glyph_bit(d, oy >> s, (ox >> s) & 15);
  endfunction

  task automatic drive_pix(input int ox, input int oy);
    exp_t e;
    pixelX = 11'(TLX + ox);
    pixelY = 11'(TLY + oy);
    sb.push_back('{model_pix(0, ox, oy, model_val, model_on), model_pix(1, ox, oy, model_val, model_on)});
    @(posedge clk); #1;
    e = sb.pop_front();
    check("draw_s0", dr0, e.e0);
    check("draw_s1", dr1, e.e1);
  endtask

  task automatic scan_all();
    for (int oy = -2; oy < 34; oy++)
      for (int ox = -2; ox < 66; ox++)
        drive_pix(ox, oy);
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rdy0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy0) check("ready_timeout", rdy0, 1);
  endtask

  task automatic load(input int v);
    wait_ready();
    value_in    = VW'(v);
    value_valid = 1'b1;
    @(posedge clk); #1;
    value_valid = 1'b0;
    check("busy_after_load", rdy0, 0);
  endtask

  task automatic commit(input int v);
    repeat (VW + 2) @(posedge clk);
    #1;
    check("busy_wait_frame", rdy0, 0);
    sof_pulse();
    check("ready_after_commit", rdy0, 1);
    check("ready_s1", rdy1, 1);
    model_val = (v > 9999) ? 9999 : v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; value_valid = 1'b0; value_in = '0; blink_en = 1'b0;
    pixelX = '0; pixelY = '0; topLeftX = 11'(TLX); topLeftY = 11'(TLY);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rdy0, 1);
    check("rst_draw", dr0, 0);
    check("rgb_s0", rgb0, 8'h00);
    check("rgb_s1", rgb1, 8'hE0);
    resetN = 1'b1;
    @(posedge clk); #1;
    scan_all();

    load(1234); commit(1234); scan_all();
    load(7);    commit(7);    scan_all();
    load(0);    commit(0);    scan_all();

    load(12000);
    value_in = VW'(55); value_valid = 1'b1;
    @(posedge clk); #1;
    value_valid = 1'b0;
    check("ignored_load_busy", rdy0, 0);
    commit(12000);
    repeat (5) begin
      @(posedge clk); #1;
      check("no_queue_ready", rdy0, 1);
    end

    load(5678);
    repeat (100) @(posedge clk);
    #1;
    check("hold_busy", rdy0, 0);
    scan_all();
    check("hold_busy_after_scan", rdy0, 0);
    sof_pulse();
    check("commit_ready", rdy0, 1);
    model_val = 5678;
    scan_all();

    load(4321);
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check("midconv_rst_ready", rdy0, 1);
    check("midconv_rst_draw", dr0, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    model_val = 0;
    scan_all();
    repeat (VW + 2) @(posedge clk);
    #1;
    sof_pulse();
    check("post_rst_ready", rdy0, 1);
    scan_all();

    load(8888); commit(8888);
    blink_en = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 6; f++) begin
      model_on = ((f / 2) % 2 == 0);
      drive_pix(53, 1);
      drive_pix(10, 63);
      sof_pulse();
    end
    blink_en = 1'b0;
    @(posedge clk); #1;
    model_on = 1'b1;
    drive_pix(53, 1);

    drive_pix(-1, 10);
    drive_pix(128, 10);
    drive_pix(127, 63);
    drive_pix(10, 63);
    drive_pix(10, 64);
    drive_pix(6, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
